msrv32_lu: RTL and testbench
============================

# msrv32_lu

Load unit of the msrv32 RV32I core. It takes the 32-bit word returned by the AHB data bus and extracts the byte, halfword or word selected by the low two bits of the effective address. It then zero- or sign-extends the result and presents it to the register-file write-back path. The block is a single-cycle combinational datapath with an asynchronous active-low reset override. It sits between the data-bus interface and the write-back mux.

## Interface
- No parameters.
- clk_in — input, 1 bit. Core clock. One clock domain. No state in this block is clocked; the port exists for interface uniformity with sibling msrv32 units.
- rst_in — input, 1 bit. Asynchronous, active-low reset.
- load_size_in — input, 2 bits. Access size: 00 = byte, 01 = halfword, 10 or 11 = word.
- load_unsigned_in — input, 1 bit. 1 = zero-extend (LBU/LHU); 0 = sign-extend (LB/LH).
- data_in — input, 32 bits. Raw word read from the data bus, little-endian.
- iadder_1_to_0_in — input, 2 bits. Effective address bits [1:0], i.e. the byte offset within the word.
- ahb_resp_in — input, 1 bit. Bus response: 0 = data valid; 1 = bus not ready / wait.
- lu_output — output, 32 bits. Extended load result.

## Operation
- **Reset.** While rst_in = 0, lu_output = 32'h0000_0000, regardless of all other inputs. Reset takes priority over ahb_resp_in.
- **Bus not ready.** When rst_in = 1 and ahb_resp_in = 1, lu_output is driven to high impedance (32'hZZZZ_ZZZZ).
- **Normal operation.** When rst_in = 1 and ahb_resp_in = 0, the result depends on load_size_in:
  - **Byte (00).** Select byte = data_in[8*k+7 : 8*k], where k = iadder_1_to_0_in.
    - Unsigned: {24'h0, byte}.
    - Signed: {24{byte[7]}, byte}.
  - **Halfword (01).** Select hw = data_in[31:16] if iadder_1_to_0_in[1] = 1, else data_in[15:0]. iadder_1_to_0_in[0] is ignored, so misaligned offsets 01 and 11 alias to 00 and 10. Misalignment traps are handled elsewhere.
    - Unsigned: {16'h0, hw}.
    - Signed: {16{hw[15]}, hw}.
  - **Word (10, 11).** lu_output = data_in. iadder_1_to_0_in and load_unsigned_in are ignored.
- No X propagation on the select paths: every case and mux has a full default, and there are no latches.

## Timing
- Fully combinational from data_in, load_size_in, load_unsigned_in, iadder_1_to_0_in and ahb_resp_in to lu_output. Zero-cycle latency: the result is valid in the same cycle the bus returns data.
- **Reset.** Assertion of rst_in forces lu_output to 0 immediately, with no clock edge required. On deassertion, the output resumes the combinational function in the same delta.
- No handshake or back-pressure is generated. The consumer samples lu_output on its own clk_in edge, only in cycles where ahb_resp_in = 0.
- **Simultaneous events.** rst_in = 0 together with ahb_resp_in = 1 gives lu_output = 0, not Z.
- Any input change while ahb_resp_in = 1 has no visible effect until ahb_resp_in returns to 0.

## Test plan
- **Reset and bus-wait priority.**
  - rst_in = 0 with data_in = 32'hFFFF_FFFF, word size, ahb_resp_in = 0 → lu_output = 32'h0000_0000.
  - rst_in = 0 with ahb_resp_in = 1 → lu_output = 32'h0000_0000.
- **Byte loads, signed, offsets 0 and 1.** rst_in = 1, ahb_resp_in = 0, data_in = 32'h1234_5678, size 00, load_unsigned_in = 0:
  - offset 00 → 32'h0000_0078.
  - offset 01 → 32'h0000_0056.
- **Halfword load, upper half.** Same data, size 01, offset 10 → 32'h0000_1234.
  - Then offset 11 → 32'h0000_1234 (bit 0 ignored).
- **Sign vs. zero extension.** data_in = 32'h80F0_7FFF:
  - byte, offset 10, signed → 32'hFFFF_FFF0; unsigned → 32'h0000_00F0.
  - halfword, offset 10, signed → 32'hFFFF_80F0; unsigned → 32'h0000_80F0.
  - byte, offset 01, signed → 32'h0000_007F.
- **Word load.** data_in = 32'hDEAD_BEEF, size 10 and size 11, any offset, either load_unsigned_in value → 32'hDEAD_BEEF.
- **Bus not ready.** Any of the above with ahb_resp_in = 1 → lu_output = 32'hZZZZ_ZZZZ.
  - Returning ahb_resp_in to 0 restores the extracted value with no clock edge.

Source files
------------

// File: rtl/msrv32_lu.sv
// msrv32 load unit: extracts the addressed byte/halfword/word from the bus word and
// zero- or sign-extends it; combinational, with reset and bus-wait overrides on the output.
module msrv32_lu (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  iadder_1_to_0_in,
    input  logic        ahb_resp_in,
    output wire  [31:0] lu_output
);

    logic [31:0] load_data_s;
    logic        unused_s;

    // Byte lane selected by the byte offset within the little-endian word.
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] ofs);
        logic [7:0] b;
        case (ofs)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Only offset bit 1 picks the half; bit 0 aliases misaligned halfwords.
    function automatic logic [15:0] select_half(input logic [31:0] word, input logic ofs_hi);
        logic [15:0] h;
        if (ofs_hi == 1'b1) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        return h;
    endfunction

    // The clock only exists for port uniformity with sibling units.
    assign unused_s = clk_in;

    // Size decode and zero/sign extension of the selected lane.
    always_comb begin
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        load_data_s = 32'h0000_0000;
        byte_s      = select_byte(data_in, iadder_1_to_0_in);
        half_s      = select_half(data_in, iadder_1_to_0_in[1]);
        case (load_size_in)
            2'b00: begin
                if (load_unsigned_in == 1'b1) begin
                    load_data_s = {24'h00_0000, byte_s};
                end else begin
                    load_data_s = {{24{byte_s[7]}}, byte_s};
                end
            end
            2'b01: begin
                if (load_unsigned_in == 1'b1) begin
                    load_data_s = {16'h0000, half_s};
                end else begin
                    load_data_s = {{16{half_s[15]}}, half_s};
                end
            end
            2'b10:   load_data_s = data_in;
            2'b11:   load_data_s = data_in;
            default: load_data_s = 32'h0000_0000;
        endcase
    end

    // Reset wins over bus-wait; bus-wait releases the write-back path.
    assign lu_output = (rst_in == 1'b0)      ? 32'h0000_0000 :
                       (ahb_resp_in == 1'b1) ? 32'hzzzz_zzzz :
                                               load_data_s;

endmodule

// File: tb/tb_msrv32_lu.sv
// Directed-vector scoreboard bench for msrv32_lu: stimulus pushes expected results,
// a monitor on the falling edge pops and compares. The output net is pulled high so
// a released (high-impedance) output reads as all ones.
module tb_msrv32_lu;

    logic        clk_in;
    logic        rst_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] data_in;
    logic [1:0]  iadder_1_to_0_in;
    logic        ahb_resp_in;
    tri1  [31:0] lu_output;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t expq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;

    localparam logic [31:0] PULLED = 32'hFFFF_FFFF;

    msrv32_lu dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .data_in          (data_in),
        .iadder_1_to_0_in (iadder_1_to_0_in),
        .ahb_resp_in      (ahb_resp_in),
        .lu_output        (lu_output)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Monitor: compare the output against the oldest expectation each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_cmp++;
                if (lu_output !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, lu_output, e.exp);
                end
            end
        end
    end

    task automatic apply(input logic rst, input logic [1:0] size, input logic uns,
                         input logic [31:0] data, input logic [1:0] ofs, input logic resp,
                         input logic [31:0] exp, input string name);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst_in           = rst;
        load_size_in     = size;
        load_unsigned_in = uns;
        data_in          = data;
        iadder_1_to_0_in = ofs;
        ahb_resp_in      = resp;
        e.exp  = exp;
        e.name = name;
        expq.push_back(e);
        n_push++;
    endtask

    initial begin
        int wait_cycles;
        rst_in = 1'b0; load_size_in = 2'b10; load_unsigned_in = 1'b0;
        data_in = 32'h0; iadder_1_to_0_in = 2'b00; ahb_resp_in = 1'b0;

        apply(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0000_0000, "reset_word");
        apply(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0000_0000, "reset_over_wait");
        apply(1'b0, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b10, 1'b0, 32'h0000_0000, "reset_byte");

        apply(1'b1, 2'b00, 1'b0, 32'h1234_5678, 2'b00, 1'b0, 32'h0000_0078, "lb_ofs0");
        apply(1'b1, 2'b00, 1'b0, 32'h1234_5678, 2'b01, 1'b0, 32'h0000_0056, "lb_ofs1");
        apply(1'b1, 2'b00, 1'b0, 32'h1234_5678, 2'b10, 1'b0, 32'h0000_0034, "lb_ofs2");
        apply(1'b1, 2'b00, 1'b0, 32'h1234_5678, 2'b11, 1'b0, 32'h0000_0012, "lb_ofs3");
        apply(1'b1, 2'b01, 1'b0, 32'h1234_5678, 2'b10, 1'b0, 32'h0000_1234, "lh_ofs2");
        apply(1'b1, 2'b01, 1'b0, 32'h1234_5678, 2'b11, 1'b0, 32'h0000_1234, "lh_ofs3_alias");
        apply(1'b1, 2'b01, 1'b0, 32'h1234_5678, 2'b00, 1'b0, 32'h0000_5678, "lh_ofs0");

        apply(1'b1, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b10, 1'b0, 32'hFFFF_FFF0, "lb_sext");
        apply(1'b1, 2'b00, 1'b1, 32'h80F0_7FFF, 2'b10, 1'b0, 32'h0000_00F0, "lbu_zext");
        apply(1'b1, 2'b01, 1'b0, 32'h80F0_7FFF, 2'b10, 1'b0, 32'hFFFF_80F0, "lh_sext");
        apply(1'b1, 2'b01, 1'b1, 32'h80F0_7FFF, 2'b10, 1'b0, 32'h0000_80F0, "lhu_zext");
        apply(1'b1, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b01, 1'b0, 32'h0000_007F, "lb_pos");
        apply(1'b1, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b00, 1'b0, 32'hFFFF_FFFF, "lb_ofs0_neg");
        apply(1'b1, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b11, 1'b0, 32'hFFFF_FF80, "lb_ofs3_neg");
        apply(1'b1, 2'b00, 1'b1, 32'h80F0_7FFF, 2'b11, 1'b0, 32'h0000_0080, "lbu_ofs3");
        apply(1'b1, 2'b01, 1'b0, 32'h80F0_7FFF, 2'b01, 1'b0, 32'h0000_7FFF, "lh_ofs1_alias");

        apply(1'b1, 2'b10, 1'b1, 32'hDEAD_BEEF, 2'b01, 1'b0, 32'hDEAD_BEEF, "lw_size2");
        apply(1'b1, 2'b11, 1'b0, 32'hDEAD_BEEF, 2'b11, 1'b0, 32'hDEAD_BEEF, "lw_size3");
        apply(1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'hDEAD_BEEF, "lw_ofs2");

        apply(1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b1, PULLED,        "wait_word");
        apply(1'b1, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b10, 1'b1, PULLED,        "wait_byte");
        apply(1'b1, 2'b00, 1'b0, 32'h80F0_7FFF, 2'b10, 1'b0, 32'hFFFF_FFF0, "wait_release");
        apply(1'b1, 2'b01, 1'b1, 32'h1234_0000, 2'b00, 1'b1, PULLED,        "wait_half");
        apply(1'b1, 2'b01, 1'b1, 32'h1234_0000, 2'b00, 1'b0, 32'h0000_0000, "wait_release_zero");
        apply(1'b0, 2'b01, 1'b1, 32'h1234_0000, 2'b10, 1'b1, 32'h0000_0000, "reset_again");

        wait_cycles = 0;
        while (expq.size() > 0 && wait_cycles < 20) begin
            @(posedge clk_in);
            wait_cycles++;
        end
        @(posedge clk_in);
        n_cmp++;
        if (expq.size() != 0 || n_cmp != n_push + 1) begin
            n_fail++;
            $display("FAIL drain: pending %0d compared %0d pushed %0d", expq.size(), n_cmp - 1, n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
